// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory bus bundle shared between the fetch unit, the load/store
// unit, the arbiter and the single-port memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_ack;
    logic [DW-1:0] ls_rdata;
    logic          ls_done;
    logic          mem_read_cs;
    logic          mem_write_cs;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_ack, if_rdata, if_rvalid, ls_ack, ls_rdata, ls_done,
               mem_read_cs, mem_write_cs, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_ack, if_rdata, if_rvalid, ls_ack, ls_rdata, ls_done,
               mem_read_cs, mem_write_cs, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter/sequencer for the single-port core memory: fetch (read-only)
// and load/store (read/write), one registered access every two cycles.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
    localparam logic       OWNER_IF     = 1'b0;
    localparam logic       OWNER_LS     = 1'b1;

    state_t        state_r;
    logic          owner_r;
    logic          we_r;
    logic [3:0]    starve_cnt_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          rd_cs_r;
    logic          wr_cs_r;
    logic          if_ack_r;
    logic          ls_ack_r;
    logic          if_rvalid_r;
    logic          ls_done_r;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] ls_rdata_r;
    logic          busy_r;

    logic          req_any_s;
    logic          fetch_win_s;
    logic [3:0]    starve_next_s;

    // Winner selection and starvation counter update for the current arbitration edge
    always_comb begin
        req_any_s     = bus.if_req | bus.ls_req;
        fetch_win_s   = 1'b0;
        starve_next_s = starve_cnt_r;
        if (bus.if_req && (!bus.ls_req || (starve_cnt_r >= STARVE_LIM_C))) begin
            fetch_win_s   = 1'b1;
            starve_next_s = 4'd0;
        end else if (bus.ls_req && bus.if_req) begin
            starve_next_s = (starve_cnt_r == 4'd15) ? 4'd15 : (starve_cnt_r + 4'd1);
        end else begin
            starve_next_s = 4'd0;
        end
    end

    // Access sequencer: arbitrate in IDLE/RESP, drive strobes in ISSUE, respond in RESP
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_IF;
            we_r         <= 1'b0;
            starve_cnt_r <= 4'd0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            rd_cs_r      <= 1'b0;
            wr_cs_r      <= 1'b0;
            if_ack_r     <= 1'b0;
            ls_ack_r     <= 1'b0;
            if_rvalid_r  <= 1'b0;
            ls_done_r    <= 1'b0;
            if_rdata_r   <= '0;
            ls_rdata_r   <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if_rvalid_r <= 1'b0;
                    ls_done_r   <= 1'b0;
                    if (req_any_s) begin
                        state_r      <= ST_ISSUE;
                        busy_r       <= 1'b1;
                        starve_cnt_r <= starve_next_s;
                        owner_r      <= fetch_win_s ? OWNER_IF : OWNER_LS;
                        we_r         <= fetch_win_s ? 1'b0 : bus.ls_we;
                        mem_addr_r   <= fetch_win_s ? bus.if_addr : bus.ls_addr;
                        mem_wdata_r  <= bus.ls_wdata;
                        rd_cs_r      <= fetch_win_s | ~bus.ls_we;
                        wr_cs_r      <= ~fetch_win_s & bus.ls_we;
                        if_ack_r     <= fetch_win_s;
                        ls_ack_r     <= ~fetch_win_s;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r  <= ST_RESP;
                    busy_r   <= 1'b1;
                    rd_cs_r  <= 1'b0;
                    wr_cs_r  <= 1'b0;
                    if_ack_r <= 1'b0;
                    ls_ack_r <= 1'b0;
                    // Only the owner's read register captures; writes leave ls_rdata alone
                    if (owner_r == OWNER_LS) begin
                        ls_done_r <= 1'b1;
                        if (!we_r) begin
                            ls_rdata_r <= bus.mem_rdata;
                        end
                    end else begin
                        if_rvalid_r <= 1'b1;
                        if_rdata_r  <= bus.mem_rdata;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    rd_cs_r     <= 1'b0;
                    wr_cs_r     <= 1'b0;
                    if_ack_r    <= 1'b0;
                    ls_ack_r    <= 1'b0;
                    if_rvalid_r <= 1'b0;
                    ls_done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_ack       = if_ack_r;
    assign bus.ls_ack       = ls_ack_r;
    assign bus.if_rvalid    = if_rvalid_r;
    assign bus.ls_done      = ls_done_r;
    assign bus.if_rdata     = if_rdata_r;
    assign bus.ls_rdata     = ls_rdata_r;
    assign bus.mem_read_cs  = rd_cs_r;
    assign bus.mem_write_cs = wr_cs_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.busy         = busy_r;

endmodule
